// File: rtl/cpu_dbus_pkg.sv
// Shared types for the CPU data-bus router: FSM states, error codes, decode regions.
package cpu_dbus_pkg;

  localparam int         DEFAULT_DRAM_ABITS = 16;
  localparam logic [7:0] DEFAULT_PER_BASE   = 8'hE0;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DRAM_RD  = 2'd1,
    PER_WAIT = 2'd2,
    ERR_ACK  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_UNMAPPED = 2'b01,
    ERR_TIMEOUT  = 2'b10,
    ERR_OVERFLOW = 2'b11
  } err_code_t;

  typedef enum logic [1:0] {
    REGION_RAM      = 2'd0,
    REGION_PER      = 2'd1,
    REGION_UNMAPPED = 2'd2
  } region_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [3:0]  byte_enable;
    logic [31:0] wdata;
  } dbus_req_t;

  // RAM region: every address bit above the RAM window is zero.
  function automatic logic is_ram(input logic [31:0] addr, input int abits);
    return (addr >> abits) == 32'd0;
  endfunction

endpackage

// File: rtl/cpu_dbus_decode.sv
// Combinational address decode into RAM, peripheral or unmapped region.
module cpu_dbus_decode
  import cpu_dbus_pkg::*;
#(
  parameter int         DRAM_ABITS = DEFAULT_DRAM_ABITS,
  parameter logic [7:0] PER_BASE   = DEFAULT_PER_BASE
) (
  input  logic [31:0] addr,
  output region_t     region
);

  always_comb begin
    region = REGION_UNMAPPED;
    if (is_ram(addr, DRAM_ABITS)) begin
      region = REGION_RAM;
    end else if (addr[31:24] == PER_BASE) begin
      region = REGION_PER;
    end
  end

endmodule

// File: rtl/cpu_dbus_router.sv
// Routes CPU data-bus requests to the data RAM or the peripheral bus, one ack per accepted request,
// with a one-entry hold slot for requests arriving while busy and sticky first-error capture.
module cpu_dbus_router
  import cpu_dbus_pkg::*;
#(
  parameter int         DRAM_ABITS = DEFAULT_DRAM_ABITS,
  parameter logic [7:0] PER_BASE   = DEFAULT_PER_BASE,
  parameter int         TIMEOUT    = 255
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cpud_request,
  input  logic [31:0]           cpud_addr,
  input  logic                  cpud_write,
  input  logic [3:0]            cpud_byte_enable,
  input  logic [31:0]           cpud_wdata,
  output logic [31:0]           cpud_rdata,
  output logic                  cpud_ack,
  output logic                  dram_request,
  output logic [DRAM_ABITS-1:0] dram_addr,
  output logic                  dram_write,
  output logic [3:0]            dram_byte_enable,
  output logic [31:0]           dram_wdata,
  input  logic [31:0]           dram_rdata,
  output logic                  per_valid,
  output logic [31:0]           per_addr,
  output logic                  per_write,
  output logic [3:0]            per_byte_enable,
  output logic [31:0]           per_wdata,
  input  logic                  per_ack,
  input  logic [31:0]           per_rdata,
  input  logic                  err_clear,
  output logic                  bus_error,
  output logic [1:0]            err_code,
  output logic [31:0]           err_addr
);

  state_t      state;
  logic        hold_full;
  dbus_req_t   hold_req;
  logic [7:0]  timer;
  logic        dram_pass;
  logic [31:0] rdata_reg;

  dbus_req_t   live_req;
  dbus_req_t   sel_req;
  logic        sel_valid;
  region_t     sel_region;

  logic        err_valid;
  err_code_t   err_kind;
  logic [31:0] err_at;

  // A held request always has priority over a live one when the FSM is free.
  always_comb begin
    live_req  = '{addr: cpud_addr, write: cpud_write,
                  byte_enable: cpud_byte_enable, wdata: cpud_wdata};
    sel_req   = hold_full ? hold_req : live_req;
    sel_valid = hold_full | cpud_request;
  end

  cpu_dbus_decode #(
    .DRAM_ABITS (DRAM_ABITS),
    .PER_BASE   (PER_BASE)
  ) u_decode (
    .addr   (sel_req.addr),
    .region (sel_region)
  );

  // At most one error is reported per cycle; the in-flight transaction's error wins over an overflow.
  always_comb begin
    err_valid = 1'b0;
    err_kind  = ERR_NONE;
    err_at    = '0;
    if (state == IDLE && sel_valid && sel_region == REGION_UNMAPPED) begin
      err_valid = 1'b1;
      err_kind  = ERR_UNMAPPED;
      err_at    = sel_req.addr;
    end else if (state == PER_WAIT && !per_ack && timer == 8'(TIMEOUT)) begin
      err_valid = 1'b1;
      err_kind  = ERR_TIMEOUT;
      err_at    = per_addr;
    end else if (state != IDLE && cpud_request && hold_full) begin
      err_valid = 1'b1;
      err_kind  = ERR_OVERFLOW;
      err_at    = cpud_addr;
    end
  end

  // RAM read data arrives the cycle after the strobe, which is the ack cycle, so it bypasses the register.
  assign cpud_rdata = dram_pass ? dram_rdata : rdata_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      state            <= IDLE;
      hold_full        <= 1'b0;
      hold_req         <= '0;
      timer            <= '0;
      dram_pass        <= 1'b0;
      rdata_reg        <= '0;
      cpud_ack         <= 1'b0;
      dram_request     <= 1'b0;
      dram_addr        <= '0;
      dram_write       <= 1'b0;
      dram_byte_enable <= '0;
      dram_wdata       <= '0;
      per_valid        <= 1'b0;
      per_addr         <= '0;
      per_write        <= 1'b0;
      per_byte_enable  <= '0;
      per_wdata        <= '0;
      bus_error        <= 1'b0;
      err_code         <= ERR_NONE;
      err_addr         <= '0;
    end else begin
      cpud_ack     <= 1'b0;
      dram_request <= 1'b0;
      dram_pass    <= 1'b0;
      rdata_reg    <= '0;

      if (state != IDLE && cpud_request && !hold_full) begin
        hold_full <= 1'b1;
        hold_req  <= live_req;
      end

      case (state)
        IDLE: begin
          if (sel_valid) begin
            // Dispatching the held entry frees the slot for a simultaneous live request.
            hold_full <= hold_full & cpud_request;
            hold_req  <= live_req;
            case (sel_region)
              REGION_RAM: begin
                dram_request     <= 1'b1;
                dram_addr        <= sel_req.addr[DRAM_ABITS-1:0];
                dram_write       <= sel_req.write;
                dram_byte_enable <= sel_req.byte_enable;
                dram_wdata       <= sel_req.wdata;
                state            <= DRAM_RD;
              end
              REGION_PER: begin
                per_valid       <= 1'b1;
                per_addr        <= sel_req.addr;
                per_write       <= sel_req.write;
                per_byte_enable <= sel_req.byte_enable;
                per_wdata       <= sel_req.wdata;
                timer           <= '0;
                state           <= PER_WAIT;
              end
              default: begin
                cpud_ack <= 1'b1;
                state    <= ERR_ACK;
              end
            endcase
          end
        end

        DRAM_RD: begin
          cpud_ack  <= 1'b1;
          dram_pass <= ~dram_write;
          state     <= IDLE;
        end

        PER_WAIT: begin
          if (per_ack) begin
            per_valid <= 1'b0;
            cpud_ack  <= 1'b1;
            rdata_reg <= per_rdata;
            state     <= IDLE;
          end else if (timer == 8'(TIMEOUT)) begin
            per_valid <= 1'b0;
            cpud_ack  <= 1'b1;
            state     <= IDLE;
          end else begin
            timer <= timer + 8'd1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase

      if (err_valid && (!bus_error || err_clear)) begin
        bus_error <= 1'b1;
        err_code  <= err_kind;
        err_addr  <= err_at;
      end else if (err_clear) begin
        bus_error <= 1'b0;
        err_code  <= ERR_NONE;
        err_addr  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_cpu_dbus_router.sv
// Self-checking bench for cpu_dbus_router: directed scenarios plus randomized traffic against an in-order model.
module tb_cpu_dbus_router;

  localparam int TMO = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cpud_request = 1'b0;
  logic [31:0] cpud_addr = '0;
  logic        cpud_write = 1'b0;
  logic [3:0]  cpud_byte_enable = '0;
  logic [31:0] cpud_wdata = '0;
  logic [31:0] cpud_rdata;
  logic        cpud_ack;
  logic        dram_request;
  logic [15:0] dram_addr;
  logic        dram_write;
  logic [3:0]  dram_byte_enable;
  logic [31:0] dram_wdata;
  logic [31:0] dram_rdata = '0;
  logic        per_valid;
  logic [31:0] per_addr;
  logic        per_write;
  logic [3:0]  per_byte_enable;
  logic [31:0] per_wdata;
  logic        per_ack = 1'b0;
  logic [31:0] per_rdata = '0;
  logic        err_clear = 1'b0;
  logic        bus_error;
  logic [1:0]  err_code;
  logic [31:0] err_addr;

  always #5 clock = ~clock;

  cpu_dbus_router #(
    .DRAM_ABITS (16),
    .PER_BASE   (8'hE0),
    .TIMEOUT    (TMO)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .cpud_request     (cpud_request),
    .cpud_addr        (cpud_addr),
    .cpud_write       (cpud_write),
    .cpud_byte_enable (cpud_byte_enable),
    .cpud_wdata       (cpud_wdata),
    .cpud_rdata       (cpud_rdata),
    .cpud_ack         (cpud_ack),
    .dram_request     (dram_request),
    .dram_addr        (dram_addr),
    .dram_write       (dram_write),
    .dram_byte_enable (dram_byte_enable),
    .dram_wdata       (dram_wdata),
    .dram_rdata       (dram_rdata),
    .per_valid        (per_valid),
    .per_addr         (per_addr),
    .per_write        (per_write),
    .per_byte_enable  (per_byte_enable),
    .per_wdata        (per_wdata),
    .per_ack          (per_ack),
    .per_rdata        (per_rdata),
    .err_clear        (err_clear),
    .bus_error        (bus_error),
    .err_code         (err_code),
    .err_addr         (err_addr)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] rdata;
    bit          check_rdata;
  } exp_t;

  int          checks = 0;
  int          passes = 0;
  logic [31:0] ram     [16384];
  logic [31:0] ref_mem [16384];
  logic [31:0] per_regs[16];
  logic [31:0] ref_per [16];
  exp_t        sb[$];
  bit          ram_rd_pending = 0;
  logic [31:0] ram_rd_data = '0;
  bit          per_auto = 1;
  bit          per_force = 0;
  int          per_delay = 0;
  int          cur_delay = 0;
  int          per_hi = 0;
  int          ack_total = 0;
  bit          ack_now = 0;

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  // One clock: advance, play the RAM and peripheral, then score any ack against the model queue.
  task automatic tick();
    @(posedge clock);
    #1;
    dram_rdata = ram_rd_pending ? ram_rd_data : $urandom();
    ram_rd_pending = 0;
    if (dram_request) begin
      if (dram_write) ram[dram_addr[15:2]] = merge(ram[dram_addr[15:2]], dram_wdata, dram_byte_enable);
      else begin
        ram_rd_pending = 1;
        ram_rd_data = ram[dram_addr[15:2]];
      end
    end
    per_ack = per_force;
    per_rdata = $urandom();
    if (per_valid) begin
      if (per_hi == 0) cur_delay = per_delay;
      if (per_auto && per_hi == cur_delay) begin
        per_ack = 1'b1;
        per_rdata = per_regs[per_addr[5:2]];
        if (per_write) per_regs[per_addr[5:2]] = merge(per_regs[per_addr[5:2]], per_wdata, per_byte_enable);
      end
      per_hi++;
    end else begin
      per_hi = 0;
    end
    #1;
    ack_now = cpud_ack;
    if (cpud_ack) begin
      ack_total++;
      if (sb.size() == 0) begin
        check("unexpected_ack", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        $display("ack addr=0x%08h rdata=0x%08h", e.addr, cpud_rdata);
        if (e.check_rdata) check("ack_rdata", cpud_rdata, e.rdata);
      end
    end
  endtask

  // fate: 0 normal, 1 peripheral never answers (timeout), 2 expected to be dropped
  task automatic issue(input logic [31:0] addr, input bit write, input logic [3:0] be,
                       input logic [31:0] wdata, input int fate);
    exp_t e;
    int   idx;
    cpud_request = 1'b1;
    cpud_addr = addr;
    cpud_write = write;
    cpud_byte_enable = be;
    cpud_wdata = wdata;
    if (fate != 2) begin
      e.addr = addr;
      e.rdata = '0;
      e.check_rdata = 1;
      if (addr < 32'h0001_0000) begin
        idx = int'(addr[15:2]);
        if (write) ref_mem[idx] = merge(ref_mem[idx], wdata, be);
        else e.rdata = ref_mem[idx];
      end else if (addr[31:24] == 8'hE0 && fate == 0) begin
        idx = int'(addr[5:2]);
        if (write) begin
          ref_per[idx] = merge(ref_per[idx], wdata, be);
          e.check_rdata = 0;
        end else begin
          e.rdata = ref_per[idx];
        end
      end
      sb.push_back(e);
    end
    tick();
    cpud_request = 1'b0;
    cpud_addr = $urandom();
    cpud_wdata = $urandom();
  endtask

  task automatic wait_drain(input int max_cycles);
    for (int i = 0; i < max_cycles && sb.size() > 0; i++) tick();
    check("drain", 32'(sb.size()), 32'd0);
  endtask

  task automatic pulse_clear();
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    check("clr_bus_error", 32'(bus_error), 32'd0);
    check("clr_err_code", 32'(err_code), 32'd0);
    check("clr_err_addr", err_addr, 32'd0);
  endtask

  // Count per_valid-high cycles from the current cycle until the ack, bounded.
  task automatic count_per(input int max_cycles, output int hi, output bit got_ack);
    hi = 0;
    got_ack = 0;
    for (int i = 0; i < max_cycles; i++) begin
      if (per_valid) hi++;
      if (cpud_ack) begin
        got_ack = 1;
        break;
      end
      tick();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int          hi;
    bit          got;
    int          acks0;
    int          mism;
    bit          seen_unm;
    logic [31:0] first_unm;

    for (int i = 0; i < 16384; i++) begin
      ram[i] = 32'(i) * 32'h9E37_79B9;
      ref_mem[i] = ram[i];
    end
    for (int i = 0; i < 16; i++) begin
      per_regs[i] = 32'hC0DE_0000 | 32'(i);
      ref_per[i] = per_regs[i];
    end
    ram[16'h41] = 32'h1234_5678;
    ref_mem[16'h41] = 32'h1234_5678;

    // Reset state
    repeat (3) tick();
    check("rst_cpud_ack", 32'(cpud_ack), 32'd0);
    check("rst_cpud_rdata", cpud_rdata, 32'd0);
    check("rst_dram_request", 32'(dram_request), 32'd0);
    check("rst_per_valid", 32'(per_valid), 32'd0);
    check("rst_bus_error", 32'(bus_error), 32'd0);
    check("rst_err_code", 32'(err_code), 32'd0);
    check("rst_err_addr", err_addr, 32'd0);
    reset = 1'b0;
    tick();

    // RAM read: strobe at N+1, ack with RAM data at N+2
    issue(32'h0000_0104, 0, 4'hF, 32'h0, 0);
    check("ram_strobe_n1", 32'(dram_request), 32'd1);
    check("ram_addr_n1", 32'(dram_addr), 32'h104);
    check("ram_noack_n1", 32'(cpud_ack), 32'd0);
    tick();
    check("ram_strobe_n2", 32'(dram_request), 32'd0);
    check("ram_ack_n2", 32'(cpud_ack), 32'd1);
    check("ram_rdata_n2", cpud_rdata, 32'h1234_5678);
    tick();

    // Peripheral write acked on the third per_valid cycle
    per_auto = 1;
    per_delay = 2;
    acks0 = ack_total;
    issue(32'hE000_0010, 1, 4'hF, 32'hCAFE_F00D, 0);
    count_per(20, hi, got);
    check("per_wr_valid_cycles", 32'(hi), 32'd3);
    check("per_wr_valid_in_ack", 32'(per_valid), 32'd0);
    repeat (3) tick();
    check("per_wr_acks", 32'(ack_total - acks0), 32'd1);
    check("per_wr_bus_error", 32'(bus_error), 32'd0);
    check("per_wr_reg", per_regs[4], 32'hCAFE_F00D);

    // Peripheral timeout
    per_auto = 0;
    acks0 = ack_total;
    issue(32'hE000_0020, 0, 4'hF, 32'h0, 1);
    count_per(30, hi, got);
    check("tmo_got_ack", 32'(got), 32'd1);
    check("tmo_valid_cycles", 32'(hi), 32'(TMO + 1));
    tick();
    check("tmo_acks", 32'(ack_total - acks0), 32'd1);
    check("tmo_err_code", 32'(err_code), 32'd2);
    check("tmo_err_addr", err_addr, 32'hE000_0020);
    check("tmo_bus_error", 32'(bus_error), 32'd1);
    per_auto = 1;
    pulse_clear();

    // Unmapped accesses: first error sticks
    issue(32'h4000_0000, 0, 4'hF, 32'h0, 0);
    check("unm_ack_n1", 32'(cpud_ack), 32'd1);
    check("unm_err_code", 32'(err_code), 32'd1);
    check("unm_err_addr", err_addr, 32'h4000_0000);
    tick();
    issue(32'h4000_0004, 0, 4'hF, 32'h0, 0);
    check("unm2_ack_n1", 32'(cpud_ack), 32'd1);
    check("unm2_err_code", 32'(err_code), 32'd1);
    check("unm2_err_addr", err_addr, 32'h4000_0000);
    tick();
    pulse_clear();

    // Back-to-back: second request in the first one's ack cycle
    acks0 = ack_total;
    issue(32'h0000_0200, 0, 4'hF, 32'h0, 0);
    tick();
    check("b2b_ack_cycle", 32'(cpud_ack), 32'd1);
    issue(32'h0000_0300, 0, 4'hF, 32'h0, 0);
    wait_drain(20);
    check("b2b_acks", 32'(ack_total - acks0), 32'd2);

    // Overflow: third request while one is waiting and the hold slot is full
    per_delay = 3;
    acks0 = ack_total;
    issue(32'hE000_0008, 0, 4'hF, 32'h0, 0);
    issue(32'h0000_0400, 0, 4'hF, 32'h0, 0);
    issue(32'h0000_0500, 0, 4'hF, 32'h0, 2);
    check("ovf_err_code", 32'(err_code), 32'd3);
    check("ovf_err_addr", err_addr, 32'h0000_0500);
    check("ovf_bus_error", 32'(bus_error), 32'd1);
    wait_drain(30);
    repeat (3) tick();
    check("ovf_acks", 32'(ack_total - acks0), 32'd2);
    pulse_clear();

    // Reset while waiting on a peripheral
    per_auto = 0;
    issue(32'hE000_000C, 0, 4'hF, 32'h0, 1);
    tick();
    tick();
    sb.delete();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_mid_per_valid", 32'(per_valid), 32'd0);
    acks0 = ack_total;
    per_force = 1;
    repeat (4) tick();
    per_force = 0;
    check("rst_mid_no_ack", 32'(ack_total - acks0), 32'd0);
    check("rst_mid_bus_error", 32'(bus_error), 32'd0);
    per_auto = 1;
    issue(32'h0000_0104, 0, 4'hF, 32'h0, 0);
    tick();
    check("post_rst_ack", 32'(cpud_ack), 32'd1);
    check("post_rst_rdata", cpud_rdata, 32'h1234_5678);
    tick();

    // Randomized traffic, never more than one request in service plus one held
    seen_unm = 0;
    first_unm = '0;
    for (int n = 0; n < 300; n++) begin
      int          guard;
      int          r;
      logic [31:0] a;
      guard = 0;
      while ((sb.size() + (ack_now ? 1 : 0)) >= 2 && guard < 50) begin
        tick();
        guard++;
      end
      if (guard >= 50) check("rand_stall", 32'(guard), 32'd0);
      if ($urandom_range(0, 3) == 0) tick();
      r = int'($urandom_range(0, 9));
      per_delay = int'($urandom_range(0, TMO));
      if (r < 5) a = 32'($urandom_range(0, 63)) << 2;
      else if (r < 9) a = 32'hE000_0000 | (32'($urandom_range(0, 15)) << 2);
      else a = 32'h4000_0000 | ($urandom() & 32'h00FF_FFFC);
      if (r >= 9 && !seen_unm) begin
        seen_unm = 1;
        first_unm = a;
      end
      issue(a, bit'($urandom_range(0, 1)), 4'($urandom_range(1, 15)), $urandom(), 0);
    end
    wait_drain(100);
    check("rand_err_code", 32'(err_code), seen_unm ? 32'd1 : 32'd0);
    check("rand_err_addr", err_addr, first_unm);
    mism = 0;
    for (int i = 0; i < 64; i++) if (ram[i] !== ref_mem[i]) mism++;
    for (int i = 0; i < 16; i++) if (per_regs[i] !== ref_per[i]) mism++;
    check("rand_mem_image", 32'(mism), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
